multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: MEM_HANDSHAKE, default 1, 1 = memory states wait on mem_ready; 0 = mem_ready ignored and treated as 1.
REQ-002 Reset is synchronous and active-low on rst_n; the block runs on a single clock, clk.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 opcode  input  6  instruction[31:26] from the instruction register; stable from DECODE until the return to FETCH.
REQ-006 mem_ready  input  1  memory access completes this cycle.
REQ-007 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, Regwrite, Regdst  output  1 each  datapath strobes and mux selects.
REQ-008 PCSource, ALUSrcB, AluoP  output  2 each  mux selects and ALU-decoder op; AluoP encoding is 00 add, 01 sub, 10 funct.
REQ-009 state  output  4  current state encoding.
REQ-010 instr_done  output  1  one-cycle pulse in the final state of each instruction.
REQ-011 illegal_op  output  1  one-cycle pulse in DECODE when the opcode is unsupported.

Function
REQ-012 State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9; codes 10-15 are unreachable and go to FETCH on the next edge.
REQ-013 Outputs are decoded from state (Moore), except that IRWrite and PCWrite in FETCH are gated by mem_ready; every output not listed for a state is 0.
REQ-014 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, AluoP=00, PCSource=00, IRWrite=PCWrite=mem_ready; holds while mem_ready=0, otherwise goes to DECODE.
REQ-015 DECODE: ALUSrcA=0, ALUSrcB=11, AluoP=00.
REQ-016 DECODE transitions: opcode 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP (macro-dependent, see REQ-028/029); any other opcode -> FETCH with illegal_op=1.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, AluoP=00; opcode 100011 -> MEMRD, otherwise MEMWR.
REQ-018 MEMRD: MemRead=1, IorD=1; holds while mem_ready=0, otherwise goes to MEMWB.
REQ-019 MEMWB: Regdst=0, MemtoReg=1, Regwrite=1, instr_done=1; goes to FETCH.
REQ-020 MEMWR: MemWrite=1, IorD=1; holds while mem_ready=0; instr_done=mem_ready; goes to FETCH when mem_ready=1.
REQ-021 EXEC: ALUSrcA=1, ALUSrcB=00, AluoP=10; goes to ALUWB.
REQ-022 ALUWB: Regdst=1, MemtoReg=0, Regwrite=1, instr_done=1; goes to FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, AluoP=01, PCWriteCond=1, PCSource=01, instr_done=1; goes to FETCH.
REQ-024 Latencies with no stalls: lw 5 cycles, sw 4, R-type 4, beq 3, j 3; each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
REQ-025 MemRead and MemWrite are never asserted together; Regwrite is never asserted together with either memory strobe.

Reset
REQ-026 While rst_n=0 at a clock edge, state becomes FETCH on that edge; the edge-to-FETCH action takes priority over every transition, including a reset that arrives mid-instruction or during a stall.
REQ-027 While rst_n=0, all strobes (PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, Regwrite), instr_done and illegal_op are forced to 0 combinationally; the first fetch begins on the cycle after rst_n goes to 1.

Configuration
REQ-028 With JUMP_EN defined: opcode 000010 goes DECODE -> JUMP. JUMP drives PCWrite=1, PCSource=10, instr_done=1 and then goes to FETCH.
REQ-029 Without JUMP_EN: state 9 does not exist; opcode 000010 is illegal (illegal_op=1, then FETCH); PCSource never equals 10.

Verification
REQ-030 lw (100011), mem_ready=1 throughout -> state 0,1,2,3,4,0; Regwrite=1 and MemtoReg=1 only in state 4; instr_done pulses once.
REQ-031 sw (101011), mem_ready=0 for the first 2 cycles of MEMWR -> state 0,1,2,5,5,5,0; MemWrite=1 for 3 cycles; instr_done only in the last of them.
REQ-032 R-type (000000) -> 0,1,6,7,0 with AluoP=10 in state 6; beq (000100) -> 0,1,8,0 with PCWriteCond=1, AluoP=01.
REQ-033 opcode 001000 -> illegal_op=1 in DECODE, next state 0, no Regwrite/MemWrite; opcode 000010 -> state 9 with PCSource=10 under JUMP_EN, illegal_op without it.
REQ-034 rst_n=0 for 1 cycle while in MEMRD -> next state 0, all strobes 0 during reset; the following lw completes normally.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multicycle controller: instruction and
// memory-ready inputs, plus all strobes, mux selects and status outputs.
interface multicycle_control_if;
   logic [5:0] opcode;
   logic       mem_ready;

   logic       PCWrite;
   logic       PCWriteCond;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       MemtoReg;
   logic       IRWrite;
   logic       ALUSrcA;
   logic       Regwrite;
   logic       Regdst;
   logic [1:0] PCSource;
   logic [1:0] ALUSrcB;
   logic [1:0] AluoP;
   logic [3:0] state;
   logic       instr_done;
   logic       illegal_op;

   // master = the controller, slave = the datapath it steers
   modport master (
      input  opcode, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
             ALUSrcA, Regwrite, Regdst, PCSource, ALUSrcB, AluoP, state,
             instr_done, illegal_op
   );

   modport slave (
      output opcode, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
             ALUSrcA, Regwrite, Regdst, PCSource, ALUSrcB, AluoP, state,
             instr_done, illegal_op
   );
endinterface

// File: rtl/multicycle_control.sv
// Moore-style control FSM for a multicycle MIPS subset (lw, sw, R-type, beq, j).
// Define JUMP_EN to add the JUMP state; without it opcode 000010 is illegal.
module multicycle_control #(
   parameter int MEM_HANDSHAKE = 1
) (
   input logic                 clk,
   input logic                 rst_n,
   multicycle_control_if.master bus
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_ALUWB  = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
`ifdef JUMP_EN
   localparam logic [3:0] S_JUMP   = 4'd9;
   localparam logic [5:0] OP_J     = 6'b000010;
`endif

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   logic [3:0] state_q, state_d;
   logic       mem_ready_eff;
   logic       decode_illegal;

   assign mem_ready_eff = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;
   assign bus.state     = state_q;

   // Reset is folded into the next-state value so it overrides every transition
   always_comb begin
      state_d        = state_q;
      decode_illegal = 1'b0;
      case (state_q)
         S_FETCH:  if (mem_ready_eff) state_d = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
`ifdef JUMP_EN
               OP_J:         state_d = S_JUMP;
`endif
               default: begin
                  state_d        = S_FETCH;
                  decode_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_ready_eff) state_d = S_MEMWB;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  if (mem_ready_eff) state_d = S_FETCH;
         S_EXEC:   state_d = S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
`ifdef JUMP_EN
         S_JUMP:   state_d = S_FETCH;
`endif
         default:  state_d = S_FETCH;
      endcase
      if (!rst_n) state_d = S_FETCH;
   end

   always_ff @(posedge clk) begin
      state_q <= state_d;
   end

   always_comb begin
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.IorD        = 1'b0;
      bus.MemRead     = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.MemtoReg    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.ALUSrcA     = 1'b0;
      bus.Regwrite    = 1'b0;
      bus.Regdst      = 1'b0;
      bus.PCSource    = 2'b00;
      bus.ALUSrcB     = 2'b00;
      bus.AluoP       = 2'b00;
      bus.instr_done  = 1'b0;
      bus.illegal_op  = 1'b0;
      case (state_q)
         S_FETCH: begin
            bus.MemRead = 1'b1;
            bus.ALUSrcB = 2'b01;
            bus.IRWrite = mem_ready_eff;
            bus.PCWrite = mem_ready_eff;
         end
         S_DECODE: begin
            bus.ALUSrcB    = 2'b11;
            bus.illegal_op = decode_illegal;
         end
         S_MEMADR: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
         end
         S_MEMRD: begin
            bus.MemRead = 1'b1;
            bus.IorD    = 1'b1;
         end
         S_MEMWB: begin
            bus.MemtoReg   = 1'b1;
            bus.Regwrite   = 1'b1;
            bus.instr_done = 1'b1;
         end
         S_MEMWR: begin
            bus.MemWrite   = 1'b1;
            bus.IorD       = 1'b1;
            bus.instr_done = mem_ready_eff;
         end
         S_EXEC: begin
            bus.ALUSrcA = 1'b1;
            bus.AluoP   = 2'b10;
         end
         S_ALUWB: begin
            bus.Regdst     = 1'b1;
            bus.Regwrite   = 1'b1;
            bus.instr_done = 1'b1;
         end
         S_BRANCH: begin
            bus.ALUSrcA     = 1'b1;
            bus.AluoP       = 2'b01;
            bus.PCWriteCond = 1'b1;
            bus.PCSource    = 2'b01;
            bus.instr_done  = 1'b1;
         end
`ifdef JUMP_EN
         S_JUMP: begin
            bus.PCWrite    = 1'b1;
            bus.PCSource   = 2'b10;
            bus.instr_done = 1'b1;
         end
`endif
         default: ;
      endcase
      // Strobes and pulses are silenced while reset is held; mux selects are left alone
      if (!rst_n) begin
         bus.PCWrite     = 1'b0;
         bus.PCWriteCond = 1'b0;
         bus.IRWrite     = 1'b0;
         bus.MemRead     = 1'b0;
         bus.MemWrite    = 1'b0;
         bus.Regwrite    = 1'b0;
         bus.instr_done  = 1'b0;
         bus.illegal_op  = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a per-instruction reference model
// queues the expected per-cycle outputs and a negedge monitor compares them.
module tb_multicycle_control;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rdst;
      logic [1:0] pcs, asb, aop;
      logic       done, ill;
   } exp_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   exp_t expQ[$];

   multicycle_control_if bus();

   multicycle_control dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t blank(input logic [3:0] s);
      exp_t e;
      e    = '0;
      e.st = s;
      return e;
   endfunction

   // 0=lw 1=sw 2=R-type 3=beq 4=jump 5=illegal
   function automatic int classify(input logic [5:0] op);
      case (op)
         6'b100011: return 0;
         6'b101011: return 1;
         6'b000000: return 2;
         6'b000100: return 3;
`ifdef JUMP_EN
         6'b000010: return 4;
`endif
         default:   return 5;
      endcase
   endfunction

   task automatic driveCycle(input logic rn, input logic mr, input exp_t e);
      rst_n         = rn;
      bus.mem_ready = mr;
      expQ.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // One whole instruction: fetch stalls, memory stalls, optional reset inside MEMRD
   task automatic applyStimulus(input logic [5:0] op, input int fstall, input int mstall,
                                input bit rstInMemrd);
      exp_t e;
      int   cls;
      cls        = classify(op);
      bus.opcode = op;
      for (int i = 0; i < fstall; i++) begin
         e = blank(4'd0); e.mrd = 1; e.asb = 2'b01;
         driveCycle(1'b1, 1'b0, e);
      end
      e = blank(4'd0); e.mrd = 1; e.asb = 2'b01; e.irw = 1; e.pcw = 1;
      driveCycle(1'b1, 1'b1, e);
      e = blank(4'd1); e.asb = 2'b11; e.ill = (cls == 5);
      driveCycle(1'b1, 1'($urandom_range(0, 1)), e);
      case (cls)
         0, 1: begin
            e = blank(4'd2); e.asa = 1; e.asb = 2'b10;
            driveCycle(1'b1, 1'($urandom_range(0, 1)), e);
            if (cls == 0) begin
               if (rstInMemrd) begin
                  e = blank(4'd3); e.iord = 1;
                  driveCycle(1'b0, 1'($urandom_range(0, 1)), e);
               end else begin
                  for (int i = 0; i < mstall; i++) begin
                     e = blank(4'd3); e.mrd = 1; e.iord = 1;
                     driveCycle(1'b1, 1'b0, e);
                  end
                  e = blank(4'd3); e.mrd = 1; e.iord = 1;
                  driveCycle(1'b1, 1'b1, e);
                  e = blank(4'd4); e.m2r = 1; e.rw = 1; e.done = 1;
                  driveCycle(1'b1, 1'($urandom_range(0, 1)), e);
               end
            end else begin
               for (int i = 0; i < mstall; i++) begin
                  e = blank(4'd5); e.mwr = 1; e.iord = 1;
                  driveCycle(1'b1, 1'b0, e);
               end
               e = blank(4'd5); e.mwr = 1; e.iord = 1; e.done = 1;
               driveCycle(1'b1, 1'b1, e);
            end
         end
         2: begin
            e = blank(4'd6); e.asa = 1; e.aop = 2'b10;
            driveCycle(1'b1, 1'($urandom_range(0, 1)), e);
            e = blank(4'd7); e.rdst = 1; e.rw = 1; e.done = 1;
            driveCycle(1'b1, 1'($urandom_range(0, 1)), e);
         end
         3: begin
            e = blank(4'd8); e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.pcs = 2'b01; e.done = 1;
            driveCycle(1'b1, 1'($urandom_range(0, 1)), e);
         end
         4: begin
            e = blank(4'd9); e.pcw = 1; e.pcs = 2'b10; e.done = 1;
            driveCycle(1'b1, 1'($urandom_range(0, 1)), e);
         end
         default: ;
      endcase
   endtask

   task automatic checkOutput(input exp_t e);
      exp_t a;
      a.st = bus.state;      a.pcw = bus.PCWrite;   a.pcwc = bus.PCWriteCond;
      a.iord = bus.IorD;     a.mrd = bus.MemRead;   a.mwr = bus.MemWrite;
      a.m2r = bus.MemtoReg;  a.irw = bus.IRWrite;   a.asa = bus.ALUSrcA;
      a.rw = bus.Regwrite;   a.rdst = bus.Regdst;   a.pcs = bus.PCSource;
      a.asb = bus.ALUSrcB;   a.aop = bus.AluoP;     a.done = bus.instr_done;
      a.ill = bus.illegal_op;
      total++;
      if (a !== e) begin
         bad++;
         $display("[TB] FAIL cycle_outputs t=%0t state act=%0d exp=%0d vector act=%h exp=%h",
                  $time, a.st, e.st, a, e);
      end
      total++;
      if ((a.mrd && a.mwr) || (a.rw && (a.mrd || a.mwr))) begin
         bad++;
         $display("[TB] FAIL strobe_exclusive t=%0t act MemRead=%0b MemWrite=%0b Regwrite=%0b exp no overlap",
                  $time, a.mrd, a.mwr, a.rw);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      exp_t e;
      logic [5:0] pool [7];
      total         = 0;
      bad           = 0;
      rst_n         = 1'b0;
      bus.opcode    = 6'd0;
      bus.mem_ready = 1'b0;
      pool = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000, 6'b111111};

      repeat (2) @(posedge clk);
      #1;
      e = blank(4'd0); e.asb = 2'b01;
      driveCycle(1'b0, 1'b1, e);

      applyStimulus(6'b100011, 0, 0, 1'b0);
      applyStimulus(6'b101011, 0, 2, 1'b0);
      applyStimulus(6'b000000, 0, 0, 1'b0);
      applyStimulus(6'b000100, 0, 0, 1'b0);
      applyStimulus(6'b001000, 0, 0, 1'b0);
      applyStimulus(6'b000010, 0, 0, 1'b0);
      applyStimulus(6'b100011, 1, 1, 1'b1);
      applyStimulus(6'b100011, 0, 0, 1'b0);

      for (int n = 0; n < 60; n++) begin
         logic [5:0] op;
         if ($urandom_range(0, 3) == 0) op = 6'($urandom);
         else                           op = pool[$urandom_range(0, 6)];
         applyStimulus(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                       (op == 6'b100011) && ($urandom_range(0, 7) == 0));
      end

      @(negedge clk);
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL scoreboard_drain act=%0d exp=0 entries left", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
